// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP transmit arbiter: FSM states and
// the byte layout of the 8-byte UDP header.
package udp_pkg;

  localparam int LEN_UDP_HEADER = 8;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    IP_REQ,
    HDR,
    PAYLOAD
  } state_type;

  localparam logic [2:0] HDR_SRC_HI  = 3'd0;
  localparam logic [2:0] HDR_SRC_LO  = 3'd1;
  localparam logic [2:0] HDR_DST_HI  = 3'd2;
  localparam logic [2:0] HDR_DST_LO  = 3'd3;
  localparam logic [2:0] HDR_LEN_HI  = 3'd4;
  localparam logic [2:0] HDR_LEN_LO  = 3'd5;
  localparam logic [2:0] HDR_CSUM_HI = 3'd6;
  localparam logic [2:0] HDR_CSUM_LO = 3'd7;

  // Checksum bytes fall through to the default: UDP over IPv4 may send zero.
  function automatic logic [7:0] hdr_byte(
    input logic [2:0]  idx,
    input logic [15:0] src,
    input logic [15:0] dst,
    input logic [15:0] udp_len
  );
    logic [7:0] b;
    case (idx)
      HDR_SRC_HI: b = src[15:8];
      HDR_SRC_LO: b = src[7:0];
      HDR_DST_HI: b = dst[15:8];
      HDR_DST_LO: b = dst[7:0];
      HDR_LEN_HI: b = udp_len[15:8];
      HDR_LEN_LO: b = udp_len[7:0];
      default:    b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr,
// wrapping modulo N. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] pos;

  // Scan from the far end towards ptr so the last hit is the nearest one.
  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      pos = IW'((int'(ptr) + i) % N);
      if (req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
    winner = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Shares one UDP transmit path among N_REQ requesters: round-robin grant,
// IP header handshake, 8-byte UDP header, then payload pass-through.
module udp_tx_arbiter
  import udp_pkg::*;
#(
  parameter int          N_REQ    = 4,
  parameter logic [15:0] SRC_PORT = 16'h1388,
  parameter int          MAX_LEN  = 1472
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*16-1:0] req_port_d,
  input  logic [N_REQ*16-1:0] req_len,
  output logic [N_REQ-1:0]   grant,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_data_valid,
  output logic [N_REQ-1:0]   req_data_ready,
  output logic               ip_hdr_req,
  output logic [15:0]        ip_udp_len,
  input  logic               ip_hdr_done,
  output logic [7:0]         m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               len_err,
  output state_type          dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_type        state;
  state_type        next_state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gidx;
  logic [N_REQ-1:0] grant_q;
  logic [15:0]      port_q;
  logic [15:0]      len_q;
  logic [10:0]      cnt;

  logic [N_REQ-1:0] arb_winner;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;
  logic [15:0]      arb_len;
  logic             arb_oversize;

  logic [15:0]      udp_len;
  logic             hdr_end;
  logic             pay_valid;
  logic             pay_last;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (arb_winner),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  assign arb_len      = req_len[16*arb_idx +: 16];
  assign arb_oversize = arb_len > 16'(MAX_LEN);
  assign udp_len      = len_q + 16'(LEN_UDP_HEADER);
  assign hdr_end      = cnt == 11'(LEN_UDP_HEADER - 1);
  assign pay_valid    = req_data_valid[gidx];
  assign pay_last     = {5'd0, cnt} == (len_q - 16'd1);
  assign dbg_state    = state;

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = ARB;
      ARB:     next_state = (arb_any && !arb_oversize) ? IP_REQ : IDLE;
      IP_REQ:  if (ip_hdr_done) next_state = HDR;
      HDR: begin
        if (m_ready && hdr_end) next_state = (len_q == 16'd0) ? IDLE : PAYLOAD;
      end
      PAYLOAD: if (pay_valid && m_ready && pay_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant context, rotation pointer and byte counter.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ptr     <= '0;
      gidx    <= '0;
      grant_q <= '0;
      port_q  <= '0;
      len_q   <= '0;
      cnt     <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ARB: begin
          if (arb_any) begin
            ptr <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + IW'(1);
            if (arb_oversize) begin
              len_err <= 1'b1;
            end else begin
              gidx    <= arb_idx;
              grant_q <= arb_winner;
              port_q  <= req_port_d[16*arb_idx +: 16];
              len_q   <= arb_len;
            end
          end
          cnt <= '0;
        end
        HDR: begin
          if (m_ready) cnt <= hdr_end ? '0 : cnt + 11'd1;
        end
        PAYLOAD: begin
          if (pay_valid && m_ready) cnt <= pay_last ? '0 : cnt + 11'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    grant          = '0;
    req_data_ready = '0;
    ip_hdr_req     = 1'b0;
    ip_udp_len     = '0;
    m_data         = '0;
    m_valid        = 1'b0;
    m_last         = 1'b0;
    case (state)
      IP_REQ: begin
        grant      = grant_q;
        ip_hdr_req = 1'b1;
        ip_udp_len = udp_len;
      end
      HDR: begin
        grant   = grant_q;
        m_valid = 1'b1;
        m_data  = hdr_byte(cnt[2:0], SRC_PORT, port_q, udp_len);
        m_last  = (len_q == 16'd0) && hdr_end;
      end
      PAYLOAD: begin
        grant          = grant_q;
        m_data         = req_data[8*gidx +: 8];
        m_valid        = pay_valid;
        req_data_ready = grant_q & {N_REQ{m_ready}};
        m_last         = pay_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: frame-level model (pending set + rotating
// pointer, expected byte queue per grant) plus directed literal checks.
module tb_udp_tx_arbiter;
  import udp_pkg::*;

  localparam int N = 4;
  localparam int MAX_LEN = 1472;
  localparam logic [15:0] SRC = 16'h1388;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N*16-1:0]   req_port_d = '0;
  logic [N*16-1:0]   req_len = '0;
  logic [N-1:0]      grant;
  logic [N*8-1:0]    req_data = '0;
  logic [N-1:0]      req_data_valid = '0;
  logic [N-1:0]      req_data_ready;
  logic              ip_hdr_req;
  logic [15:0]       ip_udp_len;
  logic              ip_hdr_done = 1'b0;
  logic [7:0]        m_data;
  logic              m_valid;
  logic              m_last;
  logic              m_ready = 1'b0;
  logic              len_err;
  state_type         dbg_state;

  udp_tx_arbiter dut (
    .aclk(aclk), .areset(areset), .req(req), .req_port_d(req_port_d),
    .req_len(req_len), .grant(grant), .req_data(req_data),
    .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .ip_hdr_req(ip_hdr_req), .ip_udp_len(ip_udp_len), .ip_hdr_done(ip_hdr_done),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .len_err(len_err), .dbg_state(dbg_state)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int mode = 2;
  int issued[N];
  int resolved[N];
  int pidx[N];
  int len_tab[N];
  logic [15:0] port_tab[N];
  logic [7:0]  pay[N][0:1535];

  logic [8:0]  exp_q[$];
  int          grant_log[$];
  logic [7:0]  byte_log[$];
  int          udp_len_log[$];
  int          len_err_cnt = 0;

  int          mptr = 0;
  int          cur = 0;
  int          hdr_left = 0;
  logic        hdr_go = 1'b0;
  logic        frame_end = 1'b0;
  logic        prev_rst = 1'b0;
  logic [N-1:0] prev_grant = '0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_ipreq = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Downstream sink, IP header generator and payload sources.
  initial begin
    forever begin
      @(negedge aclk);
      case (mode)
        1:       m_ready = ~m_ready;
        2:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
      ip_hdr_done = ip_hdr_req && ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        if (grant[i] && pidx[i] < len_tab[i]) begin
          req_data[8*i +: 8] = pay[i][pidx[i]];
          req_data_valid[i] = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end else begin
          req_data[8*i +: 8] = 8'($urandom);
          req_data_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic decide();
    int pick;
    logic [15:0] ul;
    logic [7:0] hb[8];
    pick = -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (pick < 0 && req[c]) pick = c;
    end
    if (pick < 0) begin
      fail("decision_without_request", {len_err, grant}, 0);
    end else begin
      resolved[pick]++;
      mptr = (pick + 1) % N;
      if (len_tab[pick] > MAX_LEN) begin
        chk("reject", {len_err, grant}, {1'b1, 4'b0});
      end else begin
        chk("grant", {len_err, grant}, {1'b0, 4'(1 << pick)});
        cur = pick;
        pidx[pick] = 0;
        hdr_left = 8;
        hdr_go = 1'b0;
        grant_log.push_back(pick);
        ul = 16'(len_tab[pick] + 8);
        hb = '{SRC[15:8], SRC[7:0], port_tab[pick][15:8], port_tab[pick][7:0],
               ul[15:8], ul[7:0], 8'h00, 8'h00};
        for (int j = 0; j < 8; j++)
          exp_q.push_back({(len_tab[pick] == 0 && j == 7), hb[j]});
        for (int j = 0; j < len_tab[pick]; j++)
          exp_q.push_back({(j == len_tab[pick] - 1), pay[pick][j]});
      end
    end
  endtask

  task automatic monitor_cycle();
    logic [N-1:0] exp_rdy;
    logic in_pay;
    logic [8:0] e;
    if (frame_end) begin
      chk("grant_after_last", {grant, m_valid}, 0);
      frame_end = 1'b0;
    end
    if ((grant != '0 && prev_grant == '0) || len_err) decide();
    if (ip_hdr_req) begin
      chk("ip_udp_len", ip_udp_len, len_tab[cur] + 8);
      chk("valid_in_ipreq", m_valid, 0);
      if (!prev_ipreq) udp_len_log.push_back(int'(ip_udp_len));
    end
    if (prev_ipreq && !ip_hdr_req) hdr_go = 1'b1;
    in_pay = (exp_q.size() > 0) && (hdr_left == 0);
    exp_rdy = in_pay ? (4'(m_ready) << cur) : 4'b0;
    chk("data_ready", req_data_ready, exp_rdy);
    if (in_pay) chk("pay_valid", m_valid, req_data_valid[cur]);
    if (hdr_go && hdr_left > 0 && exp_q.size() > 0) chk("hdr_valid", m_valid, 1);
    if (prev_valid && !prev_ready && m_valid && grant == prev_grant)
      chk("hold_data", m_data, prev_data);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_byte", m_data, 0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data", m_data, e[7:0]);
        chk("m_last", m_last, e[8]);
        byte_log.push_back(m_data);
        if (hdr_left > 0) hdr_left--;
        else if (req_data_valid[cur] && req_data_ready[cur]) pidx[cur]++;
        if (e[8]) frame_end = 1'b1;
      end
    end
    if (len_err) len_err_cnt++;
    prev_grant = grant;
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
    prev_ipreq = ip_hdr_req;
  endtask

  // Compare process: samples just after the falling edge, when inputs are settled.
  initial begin
    forever begin
      @(negedge aclk);
      #1;
      if (prev_rst)
        chk("reset_outputs", {grant, req_data_ready, ip_hdr_req, ip_udp_len,
                              m_data, m_valid, m_last, len_err}, 0);
      if (areset) begin
        exp_q.delete();
        mptr = 0;
        for (int i = 0; i < N; i++) begin
          resolved[i] = issued[i];
          pidx[i] = 0;
        end
        req = '0;
        hdr_left = 0;
        hdr_go = 1'b0;
        frame_end = 1'b0;
        prev_grant = '0;
        prev_valid = 1'b0;
        prev_ipreq = 1'b0;
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        monitor_cycle();
        for (int i = 0; i < N; i++) req[i] = (issued[i] != resolved[i]);
      end
    end
  end

  task automatic issue(input int i, input logic [15:0] port, input int len);
    port_tab[i] = port;
    len_tab[i] = len;
    req_port_d[16*i +: 16] = port;
    req_len[16*i +: 16] = 16'(len);
    for (int k = 0; k < len && k < 1536; k++) pay[i][k] = 8'($urandom);
    issued[i]++;
  endtask

  function automatic logic all_resolved();
    for (int i = 0; i < N; i++) if (issued[i] != resolved[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (n < budget && !(all_resolved() && exp_q.size() == 0 && grant == '0 && !frame_end));
    if (n >= budget) fail("timeout", n, budget);
    repeat (2) @(negedge aclk);
  endtask

  task automatic reset_dut();
    @(negedge aclk);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    int b, bb, bl, le, n;
    logic [7:0] t1_exp[12];
    int ord[4];
    t1_exp = '{8'h13, 8'h88, 8'h12, 8'h34, 8'h00, 8'h0C, 8'h00, 8'h00,
               8'hAA, 8'hBB, 8'hCC, 8'hDD};
    reset_dut();

    // Single frame, no backpressure
    mode = 2;
    b = grant_log.size(); bb = byte_log.size(); bl = udp_len_log.size();
    issue(0, 16'h1234, 4);
    pay[0][0] = 8'hAA; pay[0][1] = 8'hBB; pay[0][2] = 8'hCC; pay[0][3] = 8'hDD;
    wait_done(2000);
    chk("t1_grant", grant_log[b], 0);
    chk("t1_udp_len", udp_len_log[bl], 12);
    chk("t1_count", byte_log.size() - bb, 12);
    for (int k = 0; k < 12; k++) chk("t1_byte", byte_log[bb + k], t1_exp[k]);

    // Fairness from a fresh pointer
    reset_dut();
    mode = 0;
    b = grant_log.size();
    for (int i = 0; i < N; i++) issue(i, 16'(16'h0100 + i), $urandom_range(0, 6));
    wait_done(4000);
    ord = '{0, 1, 2, 3};
    chk("fair_count", grant_log.size() - b, 4);
    for (int k = 0; k < 4; k++) chk("fair_order", grant_log[b + k], ord[k]);
    b = grant_log.size();
    issue(0, 16'h0A0A, 3);
    issue(2, 16'h0C0C, 2);
    wait_done(4000);
    chk("fair2_first", grant_log[b], 0);
    chk("fair2_second", grant_log[b + 1], 2);

    // Alternating backpressure
    mode = 1;
    bb = byte_log.size();
    issue(1, 16'hBEEF, 4);
    wait_done(2000);
    chk("bp_count", byte_log.size() - bb, 12);

    // Zero-length payload
    mode = 0;
    bb = byte_log.size(); bl = udp_len_log.size();
    issue(2, 16'h0042, 0);
    wait_done(2000);
    chk("zero_udp_len", udp_len_log[bl], 8);
    chk("zero_count", byte_log.size() - bb, 8);
    chk("zero_last_byte", byte_log[bb + 7], 8'h00);

    // Oversize rejection alongside a legal request
    b = grant_log.size(); le = len_err_cnt;
    issue(1, 16'h1111, 2000);
    issue(2, 16'h2222, 10);
    wait_done(4000);
    chk("over_len_err", len_err_cnt - le, 1);
    chk("over_grants", grant_log.size() - b, 1);
    chk("over_next", grant_log[b], 2);

    // Length boundary: MAX_LEN accepted, MAX_LEN+1 rejected
    mode = 2;
    bl = udp_len_log.size(); bb = byte_log.size();
    issue(3, 16'h3333, MAX_LEN);
    wait_done(10000);
    chk("max_udp_len", udp_len_log[bl], MAX_LEN + 8);
    chk("max_count", byte_log.size() - bb, MAX_LEN + 8);
    b = grant_log.size(); le = len_err_cnt;
    issue(0, 16'h4444, MAX_LEN + 1);
    wait_done(2000);
    chk("max1_len_err", len_err_cnt - le, 1);
    chk("max1_grants", grant_log.size() - b, 0);

    // Reset in the middle of a payload
    issue(0, 16'h5555, 4);
    n = 0;
    while (pidx[0] < 2 && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) fail("mid_reset_wait", pidx[0], 2);
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    repeat (2) @(negedge aclk);
    b = grant_log.size(); bb = byte_log.size();
    issue(0, 16'h6666, 4);
    issue(3, 16'h7777, 0);
    wait_done(4000);
    chk("rst_first", grant_log[b], 0);
    chk("rst_second", grant_log[b + 1], 3);
    chk("rst_count", byte_log.size() - bb, 20);

    // Random traffic
    for (int t = 0; t < 25; t++) begin
      int mask;
      mode = $urandom_range(0, 2);
      mask = $urandom_range(1, 15);
      for (int i = 0; i < N; i++) begin
        if (mask[i]) begin
          if ($urandom_range(0, 9) == 0)
            issue(i, 16'($urandom), $urandom_range(MAX_LEN + 1, 3000));
          else
            issue(i, 16'($urandom), $urandom_range(0, 24));
        end
      end
      wait_done(20000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
